sym_fold: RTL
=============

// Module: sym_fold
// PURPOSE
//  Front end of the symmetry-aware activation path; counterpart to the Sym output stage.
//  Folds a signed fixed-point input onto the non-negative half-domain as |x|, clamped to XMAX.
//  Forwards |x| to the function core over a valid/ready link.
//  Queues each input's sign in an in-order FIFO; the Sym stage pops it to rebuild f(x).
// PARAMETERS
//  M      4      integer bits (incl. sign) of the Q(M.N) input
//  N      8      fractional bits
//  WIDTH  M+N    total data width
//  DEPTH  8      sign FIFO entries; power of 2, >=2
//  XMAX   2**(WIDTH-1)-1   magnitude clamp, the function's saturation point
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous reset, active low
//  in_valid   in   1        x_in valid
//  in_ready   out  1        block accepts x_in this cycle
//  x_in       in   WIDTH    signed Q(M.N) input
//  out_valid  out  1        mag_out/sat_out valid
//  out_ready  in   1        core accepts mag_out
//  mag_out    out  WIDTH    folded magnitude; MSB always 0
//  sat_out    out  1        mag_out was clamped
//  sign_pop   in   1        Sym stage consumes head sign
//  sign_out   out  1        head of sign FIFO (1 = negative input)
//  sign_valid out  1        FIFO not empty
//  sign_count out  clog2(DEPTH)+1  FIFO occupancy
//  err_uflow  out  1        sticky: sign_pop seen while empty
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, mag_out=0, sat_out=0, FIFO ptrs/count=0,
//   sign_valid=0, sign_out=0, err_uflow=0. Reset mid-operation flushes all in-flight data.
//  in_ready = (!out_valid | out_ready) & (sign_count < DEPTH); combinational, no in_valid dep.
//  Accept = in_valid & in_ready. On accept, next edge: mag_out/sat_out load, out_valid=1.
//   Sign is pushed on the same edge. Latency 1 clk, throughput 1/clk without backpressure.
//  out_valid & !out_ready: mag_out, sat_out, out_valid hold stable; no new accept.
//  out_valid & out_ready & no accept: out_valid->0; mag_out keeps its last value.
//  Fold arithmetic: neg = x_in[WIDTH-1]; a = neg ? -x_in : x_in, computed at WIDTH+1 bits.
//   x_in = -2**(WIDTH-1) gives a = 2**(WIDTH-1) > XMAX, so it clamps.
//   a > XMAX -> mag_out = XMAX, sat_out = 1; else mag_out = a, sat_out = 0.
//   x_in = 0 -> sign 0, mag 0. Fractional bits pass unchanged; no rounding.
//  Sign FIFO: push = accept; pop = sign_pop & sign_valid.
//   sign_out = mem[rd_ptr], combinational; sign_out = 0 when empty.
//   Push and pop in one cycle: count unchanged, both pointers advance, wrap mod DEPTH.
//   At full, push is blocked via in_ready even if pop is concurrent (no fall-through).
//   sign_pop while empty: ignored, err_uflow=1 until reset.
//  Ordering: signs leave strictly in input order; the core must keep per-sample order.
//  sign_count counts samples folded but not yet reconstructed; it bounds the core's in-flight depth.
// TESTING  (M=4, N=8, WIDTH=12, DEPTH=8, XMAX=2047)
//  1 Hold rst_n=0 mid-stream with out_valid=1 -> all outputs 0 at once; in_ready=1 after release.
//  2 x=50 then -100 then 0, out_ready=1 -> mag 50/100/0 one clk after each accept, sat 0;
//    FIFO holds 0,1,0; popping 3 returns 0,1,0, then sign_valid=0.
//  3 x=-2048 -> mag_out=2047, sat_out=1, sign 1. Rerun with XMAX=1024, x=-1500 -> mag 1024, sat 1.
//  4 out_ready=0 for 4 clks with in_valid=1 -> mag_out stable, in_ready=0, exactly one sample held.
//  5 Never pop, stream 10 inputs -> 8 accepted, sign_count=8, in_ready=0.
//    Pop 1 -> exactly 1 more accepted.
//  6 Pop and push in the same clk at count=3 -> count stays 3, order kept.
//    Pop at count 0 -> err_uflow=1 and stays set.

Source files
------------

// File: rtl/sym_fold_if.sv
// Valid/ready link and sign-FIFO signals between the fold stage, the function core
// and the Sym output stage.
interface sym_fold_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] mag_out;
    logic             sat_out;
    logic             sign_pop;
    logic             sign_out;
    logic             sign_valid;
    logic [CW-1:0]    sign_count;
    logic             err_uflow;

    modport master (
        output in_valid, x_in, out_ready, sign_pop,
        input  in_ready, out_valid, mag_out, sat_out,
               sign_out, sign_valid, sign_count, err_uflow
    );

    modport slave (
        input  in_valid, x_in, out_ready, sign_pop,
        output in_ready, out_valid, mag_out, sat_out,
               sign_out, sign_valid, sign_count, err_uflow
    );
endinterface

// File: rtl/sym_fold.sv
// Folds a signed Q(M.N) sample to its clamped magnitude and queues the sign in order
// so the Sym stage can rebuild f(x) after the function core.
module sym_fold #(
    parameter int M     = 4,
    parameter int N     = 8,
    parameter int WIDTH = M + N,
    parameter int DEPTH = 8,
    parameter int XMAX  = 2**(WIDTH-1) - 1
) (
    input logic      clk,
    input logic      rst_n,
    sym_fold_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [WIDTH:0]  XMAX_W = (WIDTH+1)'(XMAX);
    localparam logic [CW-1:0]   FULL   = CW'(DEPTH);

    logic             neg;
    logic [WIDTH:0]   xs;
    logic [WIDTH:0]   a;
    logic             sat;
    logic [WIDTH-1:0] mag;

    logic             ov_q;
    logic [WIDTH-1:0] mag_q;
    logic             sat_q;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             err_q;

    logic accept;
    logic pop;
    logic in_rdy;

    // One extra bit so the most negative input negates to +2**(WIDTH-1) and clamps.
    always_comb begin
        neg = bus.x_in[WIDTH-1];
        xs  = {neg, bus.x_in};
        a   = neg ? -xs : xs;
        sat = a > XMAX_W;
        mag = sat ? XMAX_W[WIDTH-1:0] : a[WIDTH-1:0];
    end

    // No fall-through at full: a concurrent pop does not free a slot this cycle.
    assign in_rdy = (!ov_q || bus.out_ready) && (count != FULL);
    assign accept = bus.in_valid && in_rdy;
    assign pop    = bus.sign_pop && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q   <= 1'b0;
            mag_q  <= '0;
            sat_q  <= 1'b0;
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                ov_q        <= 1'b1;
                mag_q       <= mag;
                sat_q       <= sat;
                mem[wr_ptr] <= neg;
                wr_ptr      <= wr_ptr + AW'(1);
            end else if (bus.out_ready) begin
                ov_q <= 1'b0;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (bus.sign_pop && count == '0)
                err_q <= 1'b1;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = ov_q;
    assign bus.mag_out    = mag_q;
    assign bus.sat_out    = sat_q;
    assign bus.sign_valid = (count != '0);
    assign bus.sign_out   = (count != '0) ? mem[rd_ptr] : 1'b0;
    assign bus.sign_count = count;
    assign bus.err_uflow  = err_q;
endmodule
